host_cmd_engine: RTL and testbench

Parametrised host command engine between the byte-wide USB/UART FIFO pair and the instrument control plane. Decodes single-byte commands with a channel field and drives per-channel power-supply and function-generator enables, setpoints and ranges. Streams full-byte program frames to the programming memory and full-byte measurement frames back to the host. A cycle-bounded timeout stops the engine from hanging on a stalled FIFO.

---
 rtl/host_cmd_pkg.sv | 30 +++
 rtl/host_cmd_timeout.sv | 28 ++
 rtl/host_cmd_engine.sv | 277 +++++++++++++++++++++++++++
 tb/tb_host_cmd_engine.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_cmd_pkg.sv
// Shared opcodes, FSM state encoding and error-bit indices for the host command engine.
package host_cmd_pkg;

  localparam logic [3:0] OpEcho    = 4'h1;
  localparam logic [3:0] OpProg    = 4'h2;
  localparam logic [3:0] OpPsClr   = 4'h3;
  localparam logic [3:0] OpPsSet   = 4'h4;
  localparam logic [3:0] OpMeas    = 4'h5;
  localparam logic [3:0] OpRange   = 4'h6;
  localparam logic [3:0] OpFgClr   = 4'h7;
  localparam logic [3:0] OpEcho2   = 4'h8;
  localparam logic [3:0] OpMode    = 4'h9;
  localparam logic [3:0] OpSetpt   = 4'hA;
  localparam logic [3:0] OpRdRange = 4'hB;
  localparam logic [3:0] OpFgSet   = 4'hC;

  localparam int unsigned ErrTimeout = 0;
  localparam int unsigned ErrBadCh   = 1;
  localparam int unsigned ErrCsum    = 2;

  typedef enum logic [3:0] {
    StIdle, StCmdReq, StCmdWait, StDispatch, StArgReq, StArgWait, StArgUse,
    StWrWait, StWr, StMeasAddr, StMeasWr, StProgDone
  } state_e;

  function automatic logic is_chan_op(logic [3:0] op);
    return op inside {OpPsClr, OpPsSet, OpRange, OpFgClr, OpFgSet, OpSetpt, OpRdRange};
  endfunction

endpackage

// File: rtl/host_cmd_timeout.sv
// Wait-state cycle counter: expire_o fires on the TIMEOUT-th cycle since the last clear.
module host_cmd_timeout #(
  parameter int unsigned TIMEOUT = 2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  logic [CntW-1:0] cnt_q;

  // The clear cycle itself counts as the first cycle in the state.
  assign expire_o = !clr_i && (cnt_q == CntW'(TIMEOUT - 2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (!expire_o) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/host_cmd_engine.sv
// Byte-wide host command engine: decodes FIFO commands, drives channel controls, streams frames.
// Optional CMD_CHECKSUM_EN adds a checksum byte to program and measurement frames.
module host_cmd_engine
  import host_cmd_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned SP_W       = 12,
  parameter int unsigned PROG_BYTES = 22,
  parameter int unsigned MEAS_BYTES = 98,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned TIMEOUT    = 2500000
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             rd_en_o,
  input  logic                             rd_empty_i,
  input  logic [7:0]                       rd_data_i,
  output logic                             wr_en_o,
  input  logic                             wr_full_i,
  output logic [7:0]                       wr_data_o,
  input  logic [3:0]                       op_mode_i,
  output logic [NUM_CH-1:0]                ps_en_o,
  output logic [NUM_CH-1:0]                fg_en_o,
  output logic [NUM_CH*SP_W-1:0]           ps_sp_o,
  output logic [NUM_CH*2-1:0]              range_o,
  output logic                             prog_we_o,
  output logic [$clog2(PROG_BYTES)-1:0]    prog_addr_o,
  output logic [7:0]                       prog_wdata_o,
  output logic                             prog_ready_o,
  output logic [$clog2(MEAS_BYTES)-1:0]    meas_addr_o,
  input  logic [7:0]                       meas_data_i,
  output logic [2:0]                       err_o
);

`ifdef CMD_CHECKSUM_EN
  localparam int unsigned ProgLen = PROG_BYTES + 1;
`else
  localparam int unsigned ProgLen = PROG_BYTES;
`endif
  localparam int unsigned PaW  = $clog2(PROG_BYTES);
  localparam int unsigned MaW  = $clog2(MEAS_BYTES);
  localparam int unsigned CntW = $clog2(ProgLen + 1);

  state_e                   state_q, state_prev_q;
  logic [7:0]               cmd_q, arg0_q, out_q, wr_data_q, prog_wdata_q;
  logic [2:0]               lat_q, err_q;
  logic [CntW-1:0]          arg_cnt_q, n_args;
  logic [NUM_CH-1:0]        ps_en_q, fg_en_q, new_mask;
  logic [NUM_CH*SP_W-1:0]   ps_sp_q;
  logic [NUM_CH*2-1:0]      range_q;
  logic                     wr_en_q, prog_we_q, prog_ready_q;
  logic [PaW-1:0]           prog_addr_q;
  logic [MaW-1:0]           meas_addr_q;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]               sum_q;
`endif

  logic [3:0] op, ch, new_op, new_ch;
  logic       ch_bad, new_bad, expire, lat_done;
  logic [7:0] rsp_byte;

  assign op       = cmd_q[7:4];
  assign ch       = cmd_q[3:0];
  assign new_op   = rd_data_i[7:4];
  assign new_ch   = rd_data_i[3:0];
  assign ch_bad   = 32'(ch) >= NUM_CH;
  assign new_bad  = 32'(new_ch) >= NUM_CH;
  assign new_mask = NUM_CH'(1) << new_ch;
  assign lat_done = lat_q == 3'(RD_LAT);

  // Pops are gated by the live empty flag so rd_en never fires on an empty FIFO.
  assign rd_en_o = ((state_q == StCmdReq) || (state_q == StArgReq)) && !rd_empty_i;

  always_comb begin
    n_args = '0;
    case (op)
      OpEcho, OpEcho2, OpRange: n_args = CntW'(1);
      OpSetpt:                  n_args = CntW'(2);
      OpProg:                   n_args = CntW'(ProgLen);
      default:                  n_args = '0;
    endcase
  end

  always_comb begin
    rsp_byte = {op_mode_i, 4'h0};
    if (op == OpRdRange) rsp_byte = {6'd0, range_q[2*int'(ch) +: 2]};
  end

  host_cmd_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clr_i    ((state_q != state_prev_q) || (state_q == StIdle)),
    .expire_o (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      state_prev_q <= StIdle;
      cmd_q        <= '0;
      arg0_q       <= '0;
      out_q        <= '0;
      lat_q        <= '0;
      arg_cnt_q    <= '0;
      ps_en_q      <= '0;
      fg_en_q      <= '0;
      ps_sp_q      <= '0;
      range_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      prog_we_q    <= 1'b0;
      prog_addr_q  <= '0;
      prog_wdata_q <= '0;
      prog_ready_q <= 1'b0;
      meas_addr_q  <= '0;
      err_q        <= '0;
`ifdef CMD_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_prev_q <= state_q;
      wr_en_q      <= 1'b0;
      prog_we_q    <= 1'b0;
      prog_ready_q <= 1'b0;
      err_q        <= '0;
      if (expire) begin
        err_q[ErrTimeout] <= 1'b1;
        state_q           <= StIdle;
      end else begin
        case (state_q)
          StIdle: if (!rd_empty_i) state_q <= StCmdReq;
          StCmdReq: if (!rd_empty_i) begin
            lat_q   <= 3'd1;
            state_q <= StCmdWait;
          end
          // Last wait cycle: command byte is valid, so no-argument controls apply here.
          StCmdWait: if (lat_done) begin
            cmd_q     <= rd_data_i;
            arg_cnt_q <= '0;
`ifdef CMD_CHECKSUM_EN
            sum_q     <= '0;
`endif
            state_q   <= StDispatch;
            if (is_chan_op(new_op) && new_bad) begin
              err_q[ErrBadCh] <= 1'b1;
            end else begin
              case (new_op)
                OpPsClr: ps_en_q <= ps_en_q & ~new_mask;
                OpPsSet: ps_en_q <= ps_en_q | new_mask;
                OpFgClr: fg_en_q <= fg_en_q & ~new_mask;
                OpFgSet: fg_en_q <= fg_en_q | new_mask;
                default: ;
              endcase
            end
          end else begin
            lat_q <= lat_q + 3'd1;
          end
          StDispatch: begin
            case (op)
              OpEcho, OpEcho2, OpProg, OpRange, OpSetpt: state_q <= StArgReq;
              OpMeas: begin
                meas_addr_q <= '0;
                state_q     <= StMeasAddr;
              end
              OpMode, OpRdRange: begin
                out_q <= rsp_byte;
                if (op == OpRdRange && ch_bad) begin
                  state_q <= StIdle;
                end else if (!wr_full_i) begin
                  wr_en_q   <= 1'b1;
                  wr_data_q <= rsp_byte;
                  state_q   <= StWr;
                end else begin
                  state_q <= StWrWait;
                end
              end
              default: state_q <= StIdle;
            endcase
          end
          StArgReq: if (!rd_empty_i) begin
            lat_q   <= 3'd1;
            state_q <= StArgWait;
          end
          StArgWait: if (lat_done) begin
            arg_cnt_q <= arg_cnt_q + CntW'(1);
`ifdef CMD_CHECKSUM_EN
            sum_q     <= sum_q + rd_data_i;
`endif
            state_q   <= StArgUse;
            case (op)
              OpEcho, OpEcho2: out_q <= rd_data_i;
              OpProg: if (arg_cnt_q < CntW'(PROG_BYTES)) begin
                prog_we_q    <= 1'b1;
                prog_addr_q  <= PaW'(arg_cnt_q);
                prog_wdata_q <= rd_data_i;
              end
              OpRange: if (!ch_bad) range_q[2*int'(ch) +: 2] <= rd_data_i[1:0];
              OpSetpt: begin
                if (arg_cnt_q == '0) arg0_q <= rd_data_i;
                else if (!ch_bad) ps_sp_q[SP_W*int'(ch) +: SP_W] <= SP_W'({arg0_q, rd_data_i});
              end
              default: ;
            endcase
          end else begin
            lat_q <= lat_q + 3'd1;
          end
          StArgUse: begin
            if (arg_cnt_q != n_args) begin
              state_q <= StArgReq;
            end else if (op == OpEcho || op == OpEcho2) begin
              if (!wr_full_i) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= out_q;
                state_q   <= StWr;
              end else begin
                state_q <= StWrWait;
              end
            end else if (op == OpProg) begin
`ifdef CMD_CHECKSUM_EN
              if (sum_q == 8'd0) prog_ready_q <= 1'b1;
              else err_q[ErrCsum] <= 1'b1;
`else
              prog_ready_q <= 1'b1;
`endif
              state_q <= StProgDone;
            end else begin
              state_q <= StIdle;
            end
          end
          StWrWait: if (!wr_full_i) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= out_q;
            state_q   <= StWr;
          end
          StWr:       state_q <= StIdle;
          StMeasAddr: state_q <= StMeasWr;
          StMeasWr: if (!wr_full_i) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= meas_data_i;
            if (meas_addr_q == MaW'(MEAS_BYTES - 1)) begin
`ifdef CMD_CHECKSUM_EN
              out_q   <= 8'd0 - (sum_q + meas_data_i);
              state_q <= StWrWait;
`else
              state_q <= StIdle;
`endif
            end else begin
              meas_addr_q <= meas_addr_q + MaW'(1);
              state_q     <= StMeasAddr;
            end
`ifdef CMD_CHECKSUM_EN
            sum_q <= sum_q + meas_data_i;
`endif
          end
          StProgDone: state_q <= StIdle;
          default:    state_q <= StIdle;
        endcase
      end
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_data_o    = wr_data_q;
  assign ps_en_o      = ps_en_q;
  assign fg_en_o      = fg_en_q;
  assign ps_sp_o      = ps_sp_q;
  assign range_o      = range_q;
  assign prog_we_o    = prog_we_q;
  assign prog_addr_o  = prog_addr_q;
  assign prog_wdata_o = prog_wdata_q;
  assign prog_ready_o = prog_ready_q;
  assign meas_addr_o  = meas_addr_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_host_cmd_engine.sv
// Directed bench for host_cmd_engine with FIFO, measurement-memory and program-port models.
module tb_host_cmd_engine;

  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned SP_W       = 12;
  localparam int unsigned PROG_BYTES = 22;
  localparam int unsigned MEAS_BYTES = 98;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned TIMEOUT    = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_en, rd_empty = 1'b1, wr_en, wr_full = 1'b0;
  logic [7:0]  rd_data = 8'd0, wr_data, prog_wdata, meas_data = 8'd0;
  logic [3:0]  op_mode = 4'h7;
  logic [1:0]  ps_en, fg_en;
  logic [23:0] ps_sp;
  logic [3:0]  range_v;
  logic        prog_we, prog_ready;
  logic [4:0]  prog_addr;
  logic [6:0]  meas_addr;
  logic [2:0]  err;

  host_cmd_engine #(
    .NUM_CH(NUM_CH), .SP_W(SP_W), .PROG_BYTES(PROG_BYTES), .MEAS_BYTES(MEAS_BYTES),
    .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .rd_en_o(rd_en), .rd_empty_i(rd_empty), .rd_data_i(rd_data),
    .wr_en_o(wr_en), .wr_full_i(wr_full), .wr_data_o(wr_data), .op_mode_i(op_mode),
    .ps_en_o(ps_en), .fg_en_o(fg_en), .ps_sp_o(ps_sp), .range_o(range_v),
    .prog_we_o(prog_we), .prog_addr_o(prog_addr), .prog_wdata_o(prog_wdata),
    .prog_ready_o(prog_ready), .meas_addr_o(meas_addr), .meas_data_i(meas_data), .err_o(err)
  );

  always #5 clk = ~clk;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] plog_addr[$];
  logic [7:0] plog_data[$];
  logic [7:0] pipe1 = 8'd0;
  int n_cmp = 0, n_bad = 0;
  int n_ready = 0, n_to = 0, n_bc = 0, n_cs = 0;

  // Read FIFO with RD_LAT=2 pipeline, and registered measurement memory (k*3).
  always @(posedge clk) begin
    if (rd_en && rxq.size() > 0) pipe1 <= rxq.pop_front();
    rd_data   <= pipe1;
    meas_data <= 8'(int'(meas_addr) * 3);
  end

  always @(negedge clk) begin
    rd_empty = (rxq.size() == 0);
    if (!reset) begin
      if (wr_en) txq.push_back(wr_data);
      if (prog_we) begin
        plog_addr.push_back(8'(prog_addr));
        plog_data.push_back(prog_wdata);
      end
      if (prog_ready) n_ready++;
      if (err[0]) n_to++;
      if (err[1]) n_bc++;
      if (err[2]) n_cs++;
    end
  end

  task automatic send(input logic [7:0] b);
    rxq.push_back(b);
  endtask

  task automatic drain(input int extra);
    int guard = 0;
    while (rxq.size() != 0 && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    if (rxq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d bytes still queued, required 0", rxq.size());
    end
    repeat (extra) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_logs;
    @(posedge clk);
    txq.delete(); plog_addr.delete(); plog_data.delete();
    n_ready = 0; n_to = 0; n_bc = 0; n_cs = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (ps_en !== 2'b00 || fg_en !== 2'b00) begin n_bad++;
      $display("FAIL reset_en: ps_en=%b fg_en=%b, required 00 00", ps_en, fg_en); end
    n_cmp++; if (ps_sp !== 24'h0 || range_v !== 4'h0) begin n_bad++;
      $display("FAIL reset_sp_range: ps_sp=%h range=%h, required 0 0", ps_sp, range_v); end
    n_cmp++; if ({rd_en, wr_en, prog_we, prog_ready, err} !== 7'd0) begin n_bad++;
      $display("FAIL reset_strobes: got %b, required 0", {rd_en, wr_en, prog_we, prog_ready, err}); end
    n_cmp++; if (wr_data !== 8'd0 || prog_addr !== 5'd0 || meas_addr !== 7'd0) begin n_bad++;
      $display("FAIL reset_data: wr_data=%h prog_addr=%h meas_addr=%h, required 0", wr_data,
               prog_addr, meas_addr); end
  endtask

  task automatic test_enables;
    clear_logs();
    send(8'h41); send(8'hC0);
    drain(20);
    n_cmp++; if (ps_en !== 2'b10) begin n_bad++;
      $display("FAIL en_ps: got %b, required 10", ps_en); end
    n_cmp++; if (fg_en !== 2'b01) begin n_bad++;
      $display("FAIL en_fg: got %b, required 01", fg_en); end
    n_cmp++; if (ps_sp !== 24'h0 || range_v !== 4'h0 || txq.size() != 0) begin n_bad++;
      $display("FAIL en_others: ps_sp=%h range=%h tx=%0d, required 0 0 0", ps_sp, range_v,
               txq.size()); end
  endtask

  task automatic test_setpoint_range;
    clear_logs();
    send(8'hA1); send(8'hAB); send(8'hCD);
    drain(20);
    n_cmp++; if (ps_sp !== 24'hBCD000) begin n_bad++;
      $display("FAIL setpoint: got %h, required bcd000", ps_sp); end
    send(8'h61); send(8'h03); send(8'hB1);
    drain(20);
    n_cmp++; if (range_v !== 4'b1100) begin n_bad++;
      $display("FAIL range: got %b, required 1100", range_v); end
    n_cmp++; if (txq.size() != 1 || txq[0] !== 8'h03) begin n_bad++;
      $display("FAIL range_read: count=%0d byte=%h, required 1 03", txq.size(), txq[0]); end
  endtask

  task automatic test_echo_stall;
    clear_logs();
    wr_full = 1'b1;
    send(8'h13); send(8'h5A);
    repeat (50) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (txq.size() != 0) begin n_bad++;
      $display("FAIL echo_stall: %0d writes while full, required 0", txq.size()); end
    wr_full = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (txq.size() != 1 || txq[0] !== 8'h5A) begin n_bad++;
      $display("FAIL echo_release: count=%0d byte=%h, required 1 5a", txq.size(), txq[0]); end
    clear_logs();
    send(8'h15); send(8'h77); send(8'h90);
    drain(20);
    n_cmp++; if (txq.size() != 2 || txq[0] !== 8'h77 || txq[1] !== 8'h70) begin n_bad++;
      $display("FAIL echo_mode: count=%0d bytes=%h %h, required 2 77 70", txq.size(), txq[0],
               txq[1]); end
    n_cmp++; if (n_bc != 0) begin n_bad++;
      $display("FAIL echo_no_badch: err1 pulses=%0d, required 0", n_bc); end
  endtask

  task automatic test_prog;
    int bad_k = 0;
    clear_logs();
    send(8'h20);
    for (int k = 0; k < 22; k++) send(8'(k));
`ifdef CMD_CHECKSUM_EN
    send(8'h19);
`endif
    drain(20);
    n_cmp++; if (plog_addr.size() != 22) begin n_bad++;
      $display("FAIL prog_count: got %0d writes, required 22", plog_addr.size()); end
    for (int k = 0; k < plog_addr.size(); k++)
      if (plog_addr[k] !== 8'(k) || plog_data[k] !== 8'(k)) bad_k++;
    n_cmp++; if (bad_k != 0) begin n_bad++;
      $display("FAIL prog_bytes: %0d wrong addr/data entries, required 0", bad_k); end
    n_cmp++; if (n_ready != 1 || n_cs != 0) begin n_bad++;
      $display("FAIL prog_ready: ready=%0d err2=%0d, required 1 0", n_ready, n_cs); end
`ifdef CMD_CHECKSUM_EN
    clear_logs();
    send(8'h20);
    for (int k = 0; k < 22; k++) send(8'(k));
    send(8'h00);
    drain(20);
    n_cmp++; if (n_ready != 0 || n_cs != 1) begin n_bad++;
      $display("FAIL prog_badsum: ready=%0d err2=%0d, required 0 1", n_ready, n_cs); end
`endif
  endtask

  task automatic test_meas;
    int exp_n = MEAS_BYTES;
    int guard = 0;
    int bad_k = 0;
    logic [7:0] sum = 8'd0;
`ifdef CMD_CHECKSUM_EN
    exp_n = MEAS_BYTES + 1;
`endif
    clear_logs();
    send(8'h50);
    while (txq.size() < exp_n && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    drain(10);
    n_cmp++; if (txq.size() != exp_n) begin n_bad++;
      $display("FAIL meas_count: got %0d bytes, required %0d", txq.size(), exp_n); end
    for (int k = 0; k < MEAS_BYTES && k < txq.size(); k++) begin
      if (txq[k] !== 8'(k * 3)) bad_k++;
      sum = sum + 8'(k * 3);
    end
    n_cmp++; if (bad_k != 0) begin n_bad++;
      $display("FAIL meas_bytes: %0d wrong bytes, required 0", bad_k); end
`ifdef CMD_CHECKSUM_EN
    n_cmp++; if (txq[MEAS_BYTES] !== 8'(8'd0 - sum)) begin n_bad++;
      $display("FAIL meas_csum: got %h, required %h", txq[MEAS_BYTES], 8'(8'd0 - sum)); end
`endif
  endtask

  task automatic test_timeout;
    int guard = 0;
    clear_logs();
    send(8'hA0); send(8'h12);
    while (n_to == 0 && guard < TIMEOUT + 100) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    n_cmp++; if (n_to != 1) begin n_bad++;
      $display("FAIL timeout_err: err0 pulses=%0d, required 1", n_to); end
    n_cmp++; if (ps_sp !== 24'hBCD000) begin n_bad++;
      $display("FAIL timeout_sp: got %h, required bcd000", ps_sp); end
    send(8'h40);
    drain(20);
    n_cmp++; if (ps_en !== 2'b11) begin n_bad++;
      $display("FAIL timeout_next: ps_en=%b, required 11", ps_en); end
    send(8'h45);
    drain(20);
    n_cmp++; if (n_bc != 1 || ps_en !== 2'b11) begin n_bad++;
      $display("FAIL bad_channel: err1=%0d ps_en=%b, required 1 11", n_bc, ps_en); end
  endtask

  task automatic test_reset_midframe;
    clear_logs();
    send(8'h20);
    for (int k = 0; k < 5; k++) send(8'(k + 8'h40));
    drain(8);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (plog_addr.size() != 5 || n_ready != 0) begin n_bad++;
      $display("FAIL midframe: writes=%0d ready=%0d, required 5 0", plog_addr.size(), n_ready); end
    n_cmp++; if (ps_en !== 2'b00 || ps_sp !== 24'h0 || prog_addr !== 5'd0) begin n_bad++;
      $display("FAIL midframe_reset: ps_en=%b ps_sp=%h addr=%h, required 0", ps_en, ps_sp,
               prog_addr); end
  endtask

  initial begin
    test_reset();
    test_enables();
    test_setpoint_range();
    test_echo_stall();
    test_prog();
    test_meas();
    test_timeout();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
